// File: rtl/io_handshake_unit.sv
// Board-facing handshake stage: button sync/debounce plus the wait FSM that stalls the core on I/O and PAUSE.
// Define IO_DEBOUNCE_BYPASS_EN to replace the debounce counters with a plain registered synchronizer output.
module io_handshake_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SWITCH_WIDTH    = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    raw_enter,
  input  logic                    raw_continue,
  input  logic                    is_input,
  input  logic                    is_output,
  input  logic [SWITCH_WIDTH-1:0] switches,
  input  logic [DATA_WIDTH-1:0]   output_data,
  output logic                    confirmation,
  output logic                    continue_button,
  output logic [DATA_WIDTH-1:0]   input_data,
  output logic [DATA_WIDTH-1:0]   display_value,
  output logic                    waiting
);

  localparam int unsigned NBTN  = 2;
  localparam int unsigned BTN_E = 0;
  localparam int unsigned BTN_C = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OUT,
    S_WAIT_IN,
    S_WAIT_CONT,
    S_RELEASE
  } state_e;

  logic [NBTN-1:0] raw_c;
  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] level_c;
  logic [NBTN-1:0] level_prev_q;
  logic [NBTN-1:0] press_c;

  assign raw_c = {raw_continue, raw_enter};

  // Two-flop synchronizer for both buttons
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_prev_q <= '0;
    end else begin
      sync1_q      <= raw_c;
      sync2_q      <= sync1_q;
      level_prev_q <= level_c;
    end
  end

  for (genvar b = 0; b < NBTN; b++) begin : g_btn
`ifdef IO_DEBOUNCE_BYPASS_EN
    logic lvl_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        lvl_q <= 1'b0;
      end else begin
        lvl_q <= sync2_q[b];
      end
    end
`else
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             lvl_q;
    logic             lvl_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count consecutive samples that disagree with the level; any agreeing sample restarts the count
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q[b] != lvl_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d = sync2_q[b];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        lvl_q <= lvl_d;
        cnt_q <= cnt_d;
      end
    end
`endif
    assign level_c[b] = lvl_q;
  end

  assign press_c = level_c & ~level_prev_q;

  logic mode_out_c;
  logic mode_in_c;
  logic mode_pause_c;

  assign mode_pause_c = is_input & is_output;
  assign mode_out_c   = is_output & ~is_input;
  assign mode_in_c    = is_input & ~is_output;

  state_e                state_q;
  state_e                state_d;
  logic                  conf_q;
  logic                  conf_d;
  logic                  cont_q;
  logic                  cont_d;
  logic                  wait_q;
  logic                  wait_d;
  logic [DATA_WIDTH-1:0] in_q;
  logic [DATA_WIDTH-1:0] in_d;
  logic [DATA_WIDTH-1:0] disp_q;
  logic [DATA_WIDTH-1:0] disp_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      conf_q  <= 1'b0;
      cont_q  <= 1'b0;
      wait_q  <= 1'b0;
      in_q    <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      cont_q  <= cont_d;
      wait_q  <= wait_d;
      in_q    <= in_d;
      disp_q  <= disp_d;
    end
  end

  // Wait FSM: a wait state abandons silently if the core's mode changes under it
  always_comb begin
    state_d = state_q;
    conf_d  = 1'b0;
    cont_d  = 1'b0;
    in_d    = in_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: begin
        if (mode_pause_c) begin
          state_d = S_WAIT_CONT;
        end else if (mode_out_c) begin
          disp_d  = output_data;
          state_d = S_WAIT_OUT;
        end else if (mode_in_c) begin
          state_d = S_WAIT_IN;
        end
      end
      S_WAIT_OUT: begin
        if (!mode_out_c) begin
          state_d = S_IDLE;
        end else if (press_c[BTN_E]) begin
          conf_d  = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_WAIT_IN: begin
        if (!mode_in_c) begin
          state_d = S_IDLE;
        end else if (press_c[BTN_E]) begin
          in_d    = DATA_WIDTH'(switches);
          conf_d  = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_WAIT_CONT: begin
        if (!mode_pause_c) begin
          state_d = S_IDLE;
        end else if (press_c[BTN_C]) begin
          cont_d  = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (level_c == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    wait_d = (state_d == S_WAIT_OUT) || (state_d == S_WAIT_IN) || (state_d == S_WAIT_CONT);
  end

  assign confirmation    = conf_q;
  assign continue_button = cont_q;
  assign waiting         = wait_q;
  assign input_data      = in_q;
  assign display_value   = disp_q;

endmodule
